// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the board-clock reset sequencer.
`timescale 1ns/100ps
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PHY_RST   = 3'd0,
    S_DLY_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit so the largest terminal value is always representable.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return $clog2(max2(max2(a, b), max2(c, d))) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for one asynchronous status bit, cleared by the async reset.
`timescale 1ns/100ps
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer on the raw board clock: PHY/MMCM reset, IDELAYCTRL pulse, lock debounce, core release.
// Optional status outputs (o_state, o_lock_loss_count) under RESET_SEQUENCER_STATUS_EN.
`timescale 1ns/100ps
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_LOCKED            = 3,
  parameter int SYNC_STAGES         = 2,
  parameter int PHY_RESET_CYCLES    = 1000,
  parameter int IDELAY_RESET_CYCLES = 8,
  parameter int DEBOUNCE_CYCLES     = 16,
  parameter int HOLD_CYCLES         = 1024
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [N_LOCKED-1:0] i_locked,
  input  logic                i_idelayctrl_ready,
  output logic                o_mmcm_reset,
  output logic                o_idelayctrl_reset,
  output logic                o_ethernet_reset_n,
`ifdef RESET_SEQUENCER_STATUS_EN
  output logic [STATE_W-1:0]  o_state,
  output logic [LOSS_W-1:0]   o_lock_loss_count,
`endif
  output logic                o_reset
);

  localparam int CNT_W = cnt_width(PHY_RESET_CYCLES, IDELAY_RESET_CYCLES,
                                   DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] PHY_LAST  = CNT_W'(PHY_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(IDELAY_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_LOCKED:0] w_sync;
  logic              w_all_ok;
  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_next_count;

  for (genvar g = 0; g < N_LOCKED; g++) begin : g_lock_sync
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_async   (i_locked[g]),
      .o_sync    (w_sync[g])
    );
  end

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ready_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_async   (i_idelayctrl_ready),
    .o_sync    (w_sync[N_LOCKED])
  );

  assign w_all_ok = &w_sync;

  // Next state and shared counter; >= terminal checks keep the counter from ever wrapping.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    case (r_state)
      S_PHY_RST: begin
        if (r_count >= PHY_LAST) begin
          w_next_state = S_DLY_RST;
          w_next_count = {CNT_W{1'b0}};
        end else begin
          w_next_count = r_count + CNT_ONE;
        end
      end
      S_DLY_RST: begin
        if (r_count >= DLY_LAST) begin
          w_next_state = S_WAIT_LOCK;
          w_next_count = {CNT_W{1'b0}};
        end else begin
          w_next_count = r_count + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (!w_all_ok) begin
          w_next_count = {CNT_W{1'b0}};
        end else if (r_count >= DEB_LAST) begin
          w_next_state = S_HOLD;
          w_next_count = {CNT_W{1'b0}};
        end else begin
          w_next_count = r_count + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!w_all_ok) begin
          w_next_state = S_WAIT_LOCK;
          w_next_count = {CNT_W{1'b0}};
        end else if (r_count >= HOLD_LAST) begin
          w_next_state = S_RUN;
          w_next_count = {CNT_W{1'b0}};
        end else begin
          w_next_count = r_count + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!w_all_ok) begin
          w_next_state = S_WAIT_LOCK;
        end else begin
          w_next_state = S_RUN;
        end
        w_next_count = {CNT_W{1'b0}};
      end
      default: begin
        w_next_state = S_PHY_RST;
        w_next_count = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register; outputs decoded from next state so they switch on the same edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state            <= S_PHY_RST;
      r_count            <= {CNT_W{1'b0}};
      o_mmcm_reset       <= 1'b1;
      o_idelayctrl_reset <= 1'b1;
      o_ethernet_reset_n <= 1'b0;
      o_reset            <= 1'b1;
    end else begin
      r_state            <= w_next_state;
      r_count            <= w_next_count;
      o_mmcm_reset       <= (w_next_state == S_PHY_RST);
      o_idelayctrl_reset <= (w_next_state == S_PHY_RST) || (w_next_state == S_DLY_RST);
      o_ethernet_reset_n <= (w_next_state != S_PHY_RST);
      o_reset            <= (w_next_state != S_RUN);
    end
  end

`ifdef RESET_SEQUENCER_STATUS_EN
  // Status mirror of the state plus a saturating count of lock losses seen while running.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_state           <= {STATE_W{1'b0}};
      o_lock_loss_count <= {LOSS_W{1'b0}};
    end else begin
      o_state <= w_next_state;
      if ((r_state == S_RUN) && (w_next_state == S_WAIT_LOCK) &&
          (o_lock_loss_count != {LOSS_W{1'b1}})) begin
        o_lock_loss_count <= o_lock_loss_count + LOSS_W'(1);
      end else begin
        o_lock_loss_count <= o_lock_loss_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer; reference model tracks time since release and ok-streak length.
`timescale 1ns/100ps
module tb_reset_sequencer;

  localparam int NL = 3, SYNC = 2, P = 8, D = 4, Q = 4, H = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NL-1:0] locked = '1;
  logic          rdy = 1'b1;
  logic          mmcm_rst, dly_rst, eth_rst_n, core_rst;
`ifdef RESET_SEQUENCER_STATUS_EN
  logic [2:0]    state;
  logic [7:0]    loss;
`endif

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_LOCKED(NL), .SYNC_STAGES(SYNC), .PHY_RESET_CYCLES(P),
    .IDELAY_RESET_CYCLES(D), .DEBOUNCE_CYCLES(Q), .HOLD_CYCLES(H)
  ) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_locked           (locked),
    .i_idelayctrl_ready (rdy),
    .o_mmcm_reset       (mmcm_rst),
    .o_idelayctrl_reset (dly_rst),
    .o_ethernet_reset_n (eth_rst_n),
`ifdef RESET_SEQUENCER_STATUS_EN
    .o_state            (state),
    .o_lock_loss_count  (loss),
`endif
    .o_reset            (core_rst)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edges since release, length of the current run of synchronized all-ok
  // edges counted after the IDELAYCTRL pulse, and expected lock-loss count.
  int t;
  int streak;
  int m_loss;
  bit pipe [SYNC];

  task automatic model_reset();
    t = 0;
    streak = 0;
    m_loss = 0;
    for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

`ifdef RESET_SEQUENCER_STATUS_EN
  function automatic logic [2:0] exp_state();
    if (t < P)                 return 3'd0;
    else if (t < P + D)        return 3'd1;
    else if (streak >= Q + H)  return 3'd4;
    else if (streak >= Q)      return 3'd3;
    else                       return 3'd2;
  endfunction
`endif

  task automatic check_all();
    check("mmcm_reset",       mmcm_rst,  (t < P)     ? 32'd1 : 32'd0);
    check("ethernet_reset_n", eth_rst_n, (t < P)     ? 32'd0 : 32'd1);
    check("idelayctrl_reset", dly_rst,   (t < P + D) ? 32'd1 : 32'd0);
    check("core_reset",       core_rst,  (streak >= Q + H) ? 32'd0 : 32'd1);
`ifdef RESET_SEQUENCER_STATUS_EN
    check("state",            state,     exp_state());
    check("lock_loss_count",  loss,      m_loss);
`endif
  endtask

  task automatic tick();
    bit raw, seen, was_run;
    raw = (&locked) & rdy;
    @(posedge clk);
    seen = pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = raw;
    t++;
    was_run = (streak >= Q + H);
    streak = (t > P + D && seen) ? streak + 1 : 0;
    if (was_run && streak < Q + H && m_loss < 255) m_loss++;
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic async_pulse();
    #2;
    rst_n = 1'b0;
    #0.5;
    model_reset();
    check_all();
    #0.5;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;

    // Inputs already high: straight-through sequence, core released at P+D+Q+H.
    run(40);

    // Locks held low well past the PHY/IDELAY phase, then raised.
    async_pulse();
    locked = 3'b110;
    run(50);
    locked = '1;
    run(30);

    // One-cycle lock drop while in HOLD forces a fresh debounce+hold window.
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    for (int g = 0; g < 100 && streak != Q + 2; g++) tick();
    locked[1] = 1'b0;
    tick();
    locked[1] = 1'b1;
    run(40);

    // One-cycle ready drop while running.
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    run(40);

    // Asynchronous reset in the middle of HOLD.
    locked[2] = 1'b0;
    tick();
    locked[2] = 1'b1;
    for (int g = 0; g < 100 && streak != Q + 5; g++) tick();
    async_pulse();
    run(60);

    // Random glitches on any of the lock/ready inputs.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        locked = NL'($urandom_range(0, (1 << NL) - 1));
        rdy    = 1'($urandom_range(0, 1));
      end else begin
        locked = '1;
        rdy    = 1'b1;
      end
      tick();
    end
    locked = '1;
    rdy    = 1'b1;
    run(30);

    // Many lock losses to drive the loss counter into saturation.
    for (int k = 0; k < 300; k++) begin
      rdy = 1'b0;
      tick();
      rdy = 1'b1;
      run(Q + H + SYNC + 4);
    end
`ifdef RESET_SEQUENCER_STATUS_EN
    check("loss_saturated", loss, 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
